// File: rtl/uart_frame_sched_if.sv
// uart_frame_sched_if: report-request and UART TX handshake bundle for uart_frame_sched
// master drives requests and tx_busy; slave (the scheduler) drives tx_start/tx_data and status
interface uart_frame_sched_if;
  logic       ang_req;
  logic [9:0] ang_bcd;
  logic       sts_req;
  logic [7:0] sts_byte;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       frame_done;
  logic       done_id;
  logic       err_to;
  logic       sched_busy;
  modport master (
    output ang_req, ang_bcd, sts_req, sts_byte, tx_busy,
    input  tx_start, tx_data, frame_done, done_id, err_to, sched_busy
  );
  modport slave (
    input  ang_req, ang_bcd, sts_req, sts_byte, tx_busy,
    output tx_start, tx_data, frame_done, done_id, err_to, sched_busy
  );
endinterface

// File: rtl/uart_frame_sched.sv
// uart_frame_sched: round-robin 5-byte frame scheduler sharing one UART TX between angle and status reports
// clk, rst (sync, active-high); bus.slave: ang_req/ang_bcd, sts_req/sts_byte, tx_busy in;
// tx_start/tx_data, frame_done/done_id, err_to, sched_busy out
module uart_frame_sched #(
  parameter int ACC_TO = 16
) (
  input logic clk,
  input logic rst,
  uart_frame_sched_if.slave bus
);
  localparam int CW = $clog2(ACC_TO + 1);
  typedef enum logic [2:0] {IDLE, ARB, LOAD, WAIT_HI, WAIT_LO} state_t;
  state_t r_state;
  logic          r_pend_a, r_pend_s, r_rr, r_src;
  logic [9:0]    r_snap_a, r_cur;
  logic [7:0]    r_snap_s, r_tx_data;
  logic [2:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic          r_tx_start, r_frame_done, r_done_id, r_err_to;
  logic          w_pick;
  logic [7:0]    w_byte;
  function automatic logic [7:0] hex(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
  // r_rr holds the preferred source when both are pending (0 = angle)
  assign w_pick = (r_pend_a && r_pend_s) ? r_rr : r_pend_s;
  always_comb begin
    w_byte = r_idx == 3'd0 ? 8'h0D :
             r_idx == 3'd1 ? 8'h0A :
             r_idx == 3'd2 ? (r_src ? 8'h53 : 8'h30 + {6'd0, r_cur[9:8]}) :
             r_idx == 3'd3 ? (r_src ? hex(r_cur[7:4]) : 8'h30 + {4'd0, r_cur[7:4]}) :
                             (r_src ? hex(r_cur[3:0]) : 8'h30 + {4'd0, r_cur[3:0]});
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pend_a     <= 1'b0;
      r_pend_s     <= 1'b0;
      r_rr         <= 1'b0;
      r_src        <= 1'b0;
      r_snap_a     <= '0;
      r_snap_s     <= '0;
      r_cur        <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_tx_start   <= 1'b0;
      r_tx_data    <= '0;
      r_frame_done <= 1'b0;
      r_done_id    <= 1'b0;
      r_err_to     <= 1'b0;
    end else begin
      r_tx_start   <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_to     <= 1'b0;
      case (r_state)
        IDLE: if (r_pend_a || r_pend_s) r_state <= ARB;
        ARB: begin
          r_src <= w_pick;
          r_cur <= w_pick ? {2'b00, r_snap_s} : r_snap_a;
          if (w_pick) r_pend_s <= 1'b0;
          else r_pend_a <= 1'b0;
          r_idx   <= '0;
          r_state <= LOAD;
        end
        LOAD: if (!bus.tx_busy) begin
          r_tx_data  <= w_byte;
          r_tx_start <= 1'b1;
          r_cnt      <= '0;
          r_state    <= WAIT_HI;
        end
        WAIT_HI: begin
          if (bus.tx_busy) r_state <= WAIT_LO;
          else if (r_cnt == CW'(ACC_TO - 1)) begin
            r_err_to  <= 1'b1;
            r_done_id <= r_src;
            r_rr      <= ~r_src;
            r_state   <= IDLE;
          end else r_cnt <= r_cnt + 1'b1;
        end
        WAIT_LO: if (!bus.tx_busy) begin
          if (r_idx == 3'd4) begin
            r_frame_done <= 1'b1;
            r_done_id    <= r_src;
            r_rr         <= ~r_src;
            r_state      <= IDLE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= LOAD;
          end
        end
        default: r_state <= IDLE;
      endcase
      // captures come last so a request arriving in ARB re-queues the source being frozen
      if (bus.ang_req) begin
        r_pend_a <= 1'b1;
        r_snap_a <= bus.ang_bcd;
      end
      if (bus.sts_req) begin
        r_pend_s <= 1'b1;
        r_snap_s <= bus.sts_byte;
      end
    end
  end
  assign bus.tx_start   = r_tx_start;
  assign bus.tx_data    = r_tx_data;
  assign bus.frame_done = r_frame_done;
  assign bus.done_id    = r_done_id;
  assign bus.err_to     = r_err_to;
  assign bus.sched_busy = r_state != IDLE;
endmodule

// File: tb/tb_uart_frame_sched.sv
// tb_uart_frame_sched: directed and randomized checks of uart_frame_sched against a frame-level reference model
module tb_uart_frame_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  uart_frame_sched_if bus();
  uart_frame_sched #(.ACC_TO(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0, n_fail = 0, cyc = 0, bcnt = 0, start_cyc = 0, overlap = 0;
  bit en = 1'b1, m_pref = 1'b0;
  logic [7:0] bytes[$], exp_b[$];
  logic did[$], exp_id[$];
  string hx = "0123456789ABCDEF";
  // UART TX model: busy for 10 cycles per accepted byte, or never when disabled
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) bcnt <= 0;
    else if (bus.tx_start && en) bcnt <= 10;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign bus.tx_busy = bcnt != 0;
  always @(negedge clk) if (!rst) begin
    if (bus.tx_start) begin
      bytes.push_back(bus.tx_data);
      start_cyc = cyc;
      if (bus.tx_busy) overlap++;
    end
    if (bus.frame_done) did.push_back(bus.done_id);
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push_frame(input bit src, input logic [9:0] v);
    exp_b.push_back(8'h0D);
    exp_b.push_back(8'h0A);
    if (!src) begin
      exp_b.push_back(8'h30 + v[9:8]);
      exp_b.push_back(8'h30 + v[7:4]);
      exp_b.push_back(8'h30 + v[3:0]);
    end else begin
      exp_b.push_back("S");
      exp_b.push_back(hx[v[7:4]]);
      exp_b.push_back(hx[v[3:0]]);
    end
    exp_id.push_back(src);
  endtask
  task automatic drive(input int kind, input logic [9:0] a, input logic [7:0] s);
    @(negedge clk);
    bus.ang_req  = kind != 1;
    bus.ang_bcd  = a;
    bus.sts_req  = kind != 0;
    bus.sts_byte = s;
    @(negedge clk);
    bus.ang_req = 1'b0;
    bus.sts_req = 1'b0;
  endtask
  // reference order: a lone request is served; with both pending the preferred one goes first,
  // and the preference always flips to the source not served last
  task automatic model(input int kind, input logic [9:0] a, input logic [7:0] s);
    if (kind == 0) begin push_frame(0, a); m_pref = 1; end
    else if (kind == 1) begin push_frame(1, {2'b00, s}); m_pref = 0; end
    else begin
      if (!m_pref) begin push_frame(0, a); push_frame(1, {2'b00, s}); end
      else begin push_frame(1, {2'b00, s}); push_frame(0, a); end
    end
  endtask
  task automatic wait_idle();
    int quiet = 0, t = 0;
    while (quiet < 3 && t < 3000) begin
      @(negedge clk);
      quiet = bus.sched_busy ? 0 : quiet + 1;
      t++;
    end
    check("idle_reached", quiet >= 3, 1);
  endtask
  task automatic wait_bytes(input int n);
    int t = 0;
    while (bytes.size() < n && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("bytes_reached", bytes.size() >= n, 1);
  endtask
  task automatic compare(input string tag);
    check({tag, "_nbytes"}, bytes.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < bytes.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), bytes[i], exp_b[i]);
    check({tag, "_nframes"}, did.size(), exp_id.size());
    for (int i = 0; i < exp_id.size() && i < did.size(); i++)
      check($sformatf("%s_id%0d", tag, i), did[i], exp_id[i]);
    bytes.delete(); exp_b.delete(); did.delete(); exp_id.delete();
  endtask
  function automatic logic [9:0] rand_ang();
    return {2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
  endfunction
  initial begin
    logic [9:0] a;
    logic [7:0] s;
    int t;
    bus.ang_req = 0; bus.ang_bcd = 0; bus.sts_req = 0; bus.sts_byte = 0;
    repeat (3) @(negedge clk);
    check("rst_outs", {bus.tx_start, bus.tx_data, bus.frame_done, bus.done_id, bus.err_to}, 0);
    check("rst_busy", bus.sched_busy, 0);
    rst = 1'b0;
    // angle 235 and status A7
    drive(0, 10'h235, 8'h00); model(0, 10'h235, 8'h00); wait_idle(); compare("t1_ang235");
    drive(1, 10'h000, 8'hA7); model(1, 10'h000, 8'hA7); wait_idle(); compare("t2_stsA7");
    // simultaneous requests alternate
    for (int k = 0; k < 3; k++) begin
      a = rand_ang(); s = 8'($urandom);
      drive(2, a, s); model(2, a, s); wait_idle();
    end
    compare("t3_both");
    // new angle during byte 2 of an angle frame
    drive(0, 10'h090, 8'h00); wait_bytes(3);
    drive(0, 10'h180, 8'h00);
    model(0, 10'h090, 8'h00); model(0, 10'h180, 8'h00); wait_idle(); compare("t4_requeue");
    // randomized mix
    for (int k = 0; k < 8; k++) begin
      int kind = $urandom_range(0, 2);
      a = rand_ang(); s = 8'($urandom);
      drive(kind, a, s); model(kind, a, s); wait_idle();
    end
    compare("rand");
    // acceptance timeout, then the queued status frame goes out
    en = 1'b0;
    a = rand_ang(); s = 8'($urandom);
    drive(0, a, 8'h00); wait_bytes(1);
    drive(1, 10'h000, s);
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.err_to && t < 200);
    en = 1'b1;
    check("t5_err_seen", bus.err_to, 1);
    check("t5_err_delay", cyc - start_cyc, 16);
    check("t5_err_id", bus.done_id, 0);
    check("t5_no_done", did.size(), 0);
    check("t5_one_byte", bytes.size(), 1);
    bytes.delete();
    push_frame(1, {2'b00, s}); m_pref = 0;
    wait_idle(); compare("t5_next");
    // reset during WAIT_LO of byte 3
    drive(0, rand_ang(), 8'h00); wait_bytes(4);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_outs", {bus.tx_start, bus.tx_data, bus.frame_done, bus.done_id, bus.err_to}, 0);
    check("t6_busy", bus.sched_busy, 0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("t6_no_bytes", bytes.size(), 4);
    check("t6_no_frame", did.size(), 0);
    check("t6_idle", bus.sched_busy, 0);
    bytes.delete(); m_pref = 0;
    a = rand_ang(); s = 8'($urandom);
    drive(2, a, s); model(2, a, s); wait_idle(); compare("t6_after");
    check("no_overlap", overlap, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
